// File: rtl/rs_pkg.sv
// Shared defaults and entry layout for the parametrised reservation station.
package rs_pkg;

    localparam int XLEN      = 32;
    localparam int TAG_W     = 4;
    localparam int OP_W      = 6;
    localparam int IMM_W     = 32;
    localparam int ADDR_W    = 32;
    localparam int MAX_DEPTH = 64;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic              rs1_rdy;
        logic [TAG_W-1:0]  rs1_tag;
        logic [XLEN-1:0]   rs1_val;
        logic              rs2_rdy;
        logic [TAG_W-1:0]  rs2_tag;
        logic [XLEN-1:0]   rs2_val;
        logic [IMM_W-1:0]  imm;
        logic [TAG_W-1:0]  rd_tag;
        logic [ADDR_W-1:0] pc;
    } rs_entry_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int unsigned first_set(input logic [MAX_DEPTH-1:0] v);
        first_set = 0;
        for (int unsigned i = MAX_DEPTH; i > 0; i--) begin
            if (v[i-1]) first_set = i - 1;
        end
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: tracks dispatch order between slots and grants the oldest requester.
module rs_age_matrix #(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] req,
    input  logic             clear,
    output logic [DEPTH-1:0] grant
);

    // older[i][j] set means slot i was dispatched before slot j
    logic [DEPTH-1:0] older [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) older[i] <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) older[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (i == j || alloc[i] || free[i] || free[j])
                        older[i][j] <= 1'b0;
                    else if (alloc[j])
                        older[i][j] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant = req;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (req[j] && older[j][i]) grant[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rs_param_station.sv
// Reservation station: multi-CDB wakeup/bypass, age-ordered select, registered issue.
module rs_param_station #(
    parameter int DEPTH   = 16,
    parameter int NUM_CDB = 3,
    parameter int XLEN    = rs_pkg::XLEN,
    parameter int TAG_W   = rs_pkg::TAG_W,
    parameter int OP_W    = rs_pkg::OP_W,
    parameter int IMM_W   = rs_pkg::IMM_W,
    parameter int ADDR_W  = rs_pkg::ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [OP_W-1:0]            disp_op,
    input  logic                       disp_rs1_rdy,
    input  logic                       disp_rs2_rdy,
    input  logic [TAG_W-1:0]           disp_rs1_tag,
    input  logic [TAG_W-1:0]           disp_rs2_tag,
    input  logic [XLEN-1:0]            disp_rs1_val,
    input  logic [XLEN-1:0]            disp_rs2_val,
    input  logic [IMM_W-1:0]           disp_imm,
    input  logic [TAG_W-1:0]           disp_rd_tag,
    input  logic [ADDR_W-1:0]          disp_pc,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]    cdb_data,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [OP_W-1:0]            iss_op,
    output logic [XLEN-1:0]            iss_rs1_val,
    output logic [XLEN-1:0]            iss_rs2_val,
    output logic [IMM_W-1:0]           iss_imm,
    output logic [TAG_W-1:0]           iss_rd_tag,
    output logic [ADDR_W-1:0]          iss_pc,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    import rs_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic              rs1_rdy;
        logic [TAG_W-1:0]  rs1_tag;
        logic [XLEN-1:0]   rs1_val;
        logic              rs2_rdy;
        logic [TAG_W-1:0]  rs2_tag;
        logic [XLEN-1:0]   rs2_val;
        logic [IMM_W-1:0]  imm;
        logic [TAG_W-1:0]  rd_tag;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t           ent [DEPTH];
    entry_t           new_ent;
    logic [DEPTH-1:0] valid_vec, ready_vec, grant, alloc_oh, free_oh;
    logic [IDX_W-1:0] free_idx, sel_idx;
    logic             disp_fire, load;
    logic [XLEN:0]    byp1, byp2;
    logic [XLEN:0]    wk1 [DEPTH];
    logic [XLEN:0]    wk2 [DEPTH];

    // {hit, data} of the lowest-numbered bus broadcasting tag
    function automatic logic [XLEN:0] snoop(
        input logic [TAG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       vld,
        input logic [NUM_CDB*TAG_W-1:0] tags,
        input logic [NUM_CDB*XLEN-1:0]  data
    );
        logic [XLEN:0] r;
        r = '0;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            if (!r[XLEN] && vld[k] && tags[k*TAG_W +: TAG_W] == tag)
                r = {1'b1, data[k*XLEN +: XLEN]};
        end
        return r;
    endfunction

    assign full       = (count == CNT_W'(DEPTH));
    assign disp_ready = !full;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent[i].valid;
            ready_vec[i] = ent[i].valid && ent[i].rs1_rdy && ent[i].rs2_rdy;
            wk1[i]       = snoop(ent[i].rs1_tag, cdb_valid, cdb_tag, cdb_data);
            wk2[i]       = snoop(ent[i].rs2_tag, cdb_valid, cdb_tag, cdb_data);
        end
        free_idx  = IDX_W'(first_set(MAX_DEPTH'(~valid_vec)));
        sel_idx   = IDX_W'(first_set(MAX_DEPTH'(grant)));
        disp_fire = rdy && !flush && disp_valid && disp_ready;
        load      = rdy && !flush && (!iss_valid || iss_ready) && (|ready_vec);
        alloc_oh  = '0;
        if (disp_fire) alloc_oh[free_idx] = 1'b1;
        free_oh   = load ? grant : '0;

        byp1 = snoop(disp_rs1_tag, cdb_valid, cdb_tag, cdb_data);
        byp2 = snoop(disp_rs2_tag, cdb_valid, cdb_tag, cdb_data);
        new_ent.valid   = 1'b1;
        new_ent.op      = disp_op;
        new_ent.rs1_rdy = disp_rs1_rdy || byp1[XLEN];
        new_ent.rs1_tag = disp_rs1_tag;
        new_ent.rs1_val = disp_rs1_rdy ? disp_rs1_val : byp1[XLEN-1:0];
        new_ent.rs2_rdy = disp_rs2_rdy || byp2[XLEN];
        new_ent.rs2_tag = disp_rs2_tag;
        new_ent.rs2_val = disp_rs2_rdy ? disp_rs2_val : byp2[XLEN-1:0];
        new_ent.imm     = disp_imm;
        new_ent.rd_tag  = disp_rd_tag;
        new_ent.pc      = disp_pc;
    end

    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk   (clk),
        .rst_n (rst_n),
        .alloc (alloc_oh),
        .free  (free_oh),
        .req   (ready_vec),
        .clear (rdy && flush),
        .grant (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
            iss_valid   <= 1'b0;
            iss_op      <= '0;
            iss_rs1_val <= '0;
            iss_rs2_val <= '0;
            iss_imm     <= '0;
            iss_rd_tag  <= '0;
            iss_pc      <= '0;
            count       <= '0;
        end else if (rdy) begin
            if (flush) begin
                for (int unsigned i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
                iss_valid <= 1'b0;
                count     <= '0;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (ent[i].valid && !ent[i].rs1_rdy && wk1[i][XLEN]) begin
                        ent[i].rs1_rdy <= 1'b1;
                        ent[i].rs1_val <= wk1[i][XLEN-1:0];
                    end
                    if (ent[i].valid && !ent[i].rs2_rdy && wk2[i][XLEN]) begin
                        ent[i].rs2_rdy <= 1'b1;
                        ent[i].rs2_val <= wk2[i][XLEN-1:0];
                    end
                end
                if (load) begin
                    ent[sel_idx].valid <= 1'b0;
                    iss_valid   <= 1'b1;
                    iss_op      <= ent[sel_idx].op;
                    iss_rs1_val <= ent[sel_idx].rs1_val;
                    iss_rs2_val <= ent[sel_idx].rs2_val;
                    iss_imm     <= ent[sel_idx].imm;
                    iss_rd_tag  <= ent[sel_idx].rd_tag;
                    iss_pc      <= ent[sel_idx].pc;
                end else if (iss_ready) begin
                    iss_valid <= 1'b0;
                end
                // the freshly written slot is always a free one, never sel_idx
                if (disp_fire) ent[free_idx] <= new_ent;
                if (disp_fire && !load)
                    count <= count + 1'b1;
                else if (!disp_fire && load)
                    count <= count - 1'b1;
            end
        end
    end

endmodule
